// File: rtl/vga_pkg.sv
// Shared VGA timing constants, sync polarity encodings and a per-axis timing helper.
package vga_pkg;

    // 640x480@60 Hz timing (pixel clock 25.175 MHz nominal)
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    // Sync pin polarity: value of SYNC_POL that selects each behaviour
    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // Derived positions along one axis (line or frame)
    typedef struct packed {
        logic [31:0] total;
        logic [31:0] sync_start;
        logic [31:0] sync_end;
    } vga_axis_t;

    // Regions run active, front porch, sync, back porch starting at position 0
    function automatic vga_axis_t vga_axis_timing(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        vga_axis_t t;
        t.sync_start = 32'(active + fp);
        t.sync_end   = 32'(active + fp + sync);
        t.total      = 32'(active + fp + sync + bp);
        return t;
    endfunction

endpackage

// File: rtl/vga_sync_cnt.sv
// One timing axis: wrapping position counter with active-region and sync-region flags.
module vga_sync_cnt #(
    parameter int unsigned TOTAL      = 800,
    parameter int unsigned SYNC_START = 656,
    parameter int unsigned SYNC_END   = 752,
    parameter int unsigned ACTIVE     = 640,
    parameter int unsigned CNT_W      = 10
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wrap_c,
    output logic             o_active_c,
    output logic             o_sync_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_last;

    // Advance on enable, wrapping from TOTAL-1 back to 0
    always_comb begin
        at_last = (32'(count_q) == (TOTAL - 1));
        count_d = count_q;
        if (i_en) begin
            count_d = at_last ? '0 : count_q + CNT_W'(1);
        end
    end

    // Position register
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count    = count_q;
    assign o_wrap_c   = i_en && at_last;
    assign o_active_c = (32'(count_q) < ACTIVE);
    assign o_sync_c   = (32'(count_q) >= SYNC_START) && (32'(count_q) < SYNC_END);

endmodule

// File: rtl/vga_timing_gen_p_sync_cnt.sv
// Empty shell module; the per-axis counter logic is implemented in vga_sync_cnt.
module vga_timing_gen_p_sync_cnt_unused;
endmodule

// File: rtl/vga_timing_gen_p.sv
// Parametrised VGA timing generator: pixel-enable divider, h/v counters,
// pixel pull handshake and registered RGB/sync/blank pins one pixel behind the counters.
module vga_timing_gen_p
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter int unsigned COLOR_W  = 10,
    parameter int unsigned CLK_DIV  = 2,
    parameter logic        SYNC_POL = SYNC_ACTIVE_LOW,
    parameter int unsigned CNT_W    = 10
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [COLOR_W-1:0] i_red,
    input  logic [COLOR_W-1:0] i_green,
    input  logic [COLOR_W-1:0] i_blue,
    input  logic               i_clr_err,
    output logic               o_req,
    output logic               o_pix_en,
    output logic [CNT_W-1:0]   h_count,
    output logic [CNT_W-1:0]   v_count,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_vga_blank,
    output logic               o_vga_sync,
    output logic [COLOR_W-1:0] o_red,
    output logic [COLOR_W-1:0] o_green,
    output logic [COLOR_W-1:0] o_blue,
    output logic               o_frame_start,
    output logic               o_underflow
);

    localparam vga_axis_t   H_T     = vga_axis_timing(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam vga_axis_t   V_T     = vga_axis_timing(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned H_TOTAL = H_T.total;
    localparam int unsigned V_TOTAL = V_T.total;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [63:0] CNT_RANGE = 64'(1) << CNT_W;

    // Reject configurations the counters or ports cannot represent
    generate
        if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
            V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
            COLOR_W == 0 || CNT_W == 0 || CNT_W > 32 || CLK_DIV < 1 ||
            64'(H_TOTAL) > CNT_RANGE || 64'(V_TOTAL) > CNT_RANGE) begin : g_bad_params
            $error("vga_timing_gen_p: invalid parameter set");
        end
    endgenerate

    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_d;
    logic               div_last;
    logic               pix_en;
    logic               h_wrap;
    logic               h_active;
    logic               h_sync;
    logic               v_wrap;
    logic               v_active;
    logic               v_sync;
    logic               active;
    logic               req;

    logic               hsync_q;
    logic               hsync_d;
    logic               vsync_q;
    logic               vsync_d;
    logic               blank_q;
    logic               blank_d;
    logic [COLOR_W-1:0] red_q;
    logic [COLOR_W-1:0] red_d;
    logic [COLOR_W-1:0] green_q;
    logic [COLOR_W-1:0] green_d;
    logic [COLOR_W-1:0] blue_q;
    logic [COLOR_W-1:0] blue_d;
    logic               underflow_q;
    logic               underflow_d;

    // Clock divider; pixel strobe on the last count, suppressed while in reset
    always_comb begin
        div_last = (32'(div_q) == (CLK_DIV - 1));
        pix_en   = div_last && !i_rst;
        div_d    = div_last ? '0 : div_q + DIV_W'(1);
    end

    // Divider register
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    vga_sync_cnt #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_T.sync_start),
        .SYNC_END   (H_T.sync_end),
        .ACTIVE     (H_ACTIVE),
        .CNT_W      (CNT_W)
    ) u_h_cnt (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_en       (pix_en),
        .o_count    (h_count),
        .o_wrap_c   (h_wrap),
        .o_active_c (h_active),
        .o_sync_c   (h_sync)
    );

    vga_sync_cnt #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_T.sync_start),
        .SYNC_END   (V_T.sync_end),
        .ACTIVE     (V_ACTIVE),
        .CNT_W      (CNT_W)
    ) u_v_cnt (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_en       (h_wrap),
        .o_count    (v_count),
        .o_wrap_c   (v_wrap),
        .o_active_c (v_active),
        .o_sync_c   (v_sync)
    );

    // Next pin state: sample the current pixel on the strobe, otherwise hold
    always_comb begin
        active      = h_active && v_active;
        req         = pix_en && active && !i_rst;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        blank_d     = blank_q;
        red_d       = red_q;
        green_d     = green_q;
        blue_d      = blue_q;
        underflow_d = underflow_q;
        if (pix_en) begin
            hsync_d = h_sync ~^ SYNC_POL;
            vsync_d = v_sync ~^ SYNC_POL;
            blank_d = active;
            if (active && i_valid) begin
                red_d   = i_red;
                green_d = i_green;
                blue_d  = i_blue;
            end else begin
                red_d   = '0;
                green_d = '0;
                blue_d  = '0;
            end
        end
        // A fresh underflow outranks a simultaneous clear
        if (i_clr_err) begin
            underflow_d = 1'b0;
        end
        if (req && !i_valid) begin
            underflow_d = 1'b1;
        end
    end

    // Output pin registers; syncs rest at their inactive level
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            hsync_q     <= ~SYNC_POL;
            vsync_q     <= ~SYNC_POL;
            blank_q     <= 1'b0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            blank_q     <= blank_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_req         = req;
    assign o_pix_en      = pix_en;
    assign o_frame_start = pix_en && (h_count == '0) && (v_count == '0);
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_vga_blank   = blank_q;
    assign o_vga_sync    = 1'b0;
    assign o_red         = red_q;
    assign o_green       = green_q;
    assign o_blue        = blue_q;
    assign o_underflow   = underflow_q;

    // Frame wrap is implied by the counters; exposed only for completeness of the axis
    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen_p.sv
// Directed bench for vga_timing_gen_p using two tiny-timing instances:
// A (CLK_DIV=1, active-low syncs) and B (CLK_DIV=2, active-high syncs).
module tb_vga_timing_gen_p;

    logic clk;
    logic rst;

    logic       valid_a, clr_a;
    logic [9:0] red_a, green_a, blue_a;
    logic       req_a, pix_a, hs_a, vs_a, blank_a, sync_a, fs_a, uf_a;
    logic [9:0] h_a, v_a, r_a, g_a, b_a;

    logic       valid_b, clr_b;
    logic [9:0] red_b, green_b, blue_b;
    logic       req_b, pix_b, hs_b, vs_b, blank_b, sync_b, fs_b, uf_b;
    logic [9:0] h_b, v_b, r_b, g_b, b_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of instance A (current pixel and expected registered pins)
    int   mh, mv;
    logic e_hs, e_vs, e_blank, e_uf;
    logic [9:0] e_r, e_g, e_b;
    logic [31:0] drop_rgb;

    // Statistics over a sweep window
    int scyc;
    int a_hs_low, a_vs_low, a_req, a_fs, a_first_hs, a_first_vs;
    int b_pix, b_fs, b_first_fs, b_hs_hi, b_vs_hi, b_req, b_blank, b_rgb_err, b_first_hs, b_first_vs;

    vga_timing_gen_p #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .COLOR_W(10), .CLK_DIV(1), .SYNC_POL(1'b0), .CNT_W(10)
    ) u_dut_a (
        .clk(clk), .i_rst(rst), .i_valid(valid_a),
        .i_red(red_a), .i_green(green_a), .i_blue(blue_a), .i_clr_err(clr_a),
        .o_req(req_a), .o_pix_en(pix_a), .h_count(h_a), .v_count(v_a),
        .o_hsync(hs_a), .o_vsync(vs_a), .o_vga_blank(blank_a), .o_vga_sync(sync_a),
        .o_red(r_a), .o_green(g_a), .o_blue(b_a),
        .o_frame_start(fs_a), .o_underflow(uf_a)
    );

    vga_timing_gen_p #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .COLOR_W(10), .CLK_DIV(2), .SYNC_POL(1'b1), .CNT_W(10)
    ) u_dut_b (
        .clk(clk), .i_rst(rst), .i_valid(valid_b),
        .i_red(red_b), .i_green(green_b), .i_blue(blue_b), .i_clr_err(clr_b),
        .o_req(req_b), .o_pix_en(pix_b), .h_count(h_b), .v_count(v_b),
        .o_hsync(hs_b), .o_vsync(vs_b), .o_vga_blank(blank_b), .o_vga_sync(sync_b),
        .o_red(r_b), .o_green(g_b), .o_blue(b_b),
        .o_frame_start(fs_b), .o_underflow(uf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mh = 0; mv = 0;
        e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0; e_uf = 1'b0;
        e_r = '0; e_g = '0; e_b = '0;
    endtask

    task automatic clear_stats();
        scyc = 0;
        a_hs_low = 0; a_vs_low = 0; a_req = 0; a_fs = 0; a_first_hs = -1; a_first_vs = -1;
        b_pix = 0; b_fs = 0; b_first_fs = -1; b_hs_hi = 0; b_vs_hi = 0; b_req = 0;
        b_blank = 0; b_rgb_err = 0; b_first_hs = -1; b_first_vs = -1;
    endtask

    // Run ncyc clocks; optionally drop i_valid / pulse i_clr_err on one cycle of A
    task automatic sweep(input string tag, input int ncyc, input int drop_c, input int clr_c);
        int errs;
        logic act;
        logic [9:0] g;
        errs = 0;
        for (int c = 0; c < ncyc; c++) begin
            act = (mh < 8) && (mv < 4);
            if (h_a !== 10'(mh))                  errs++;
            if (v_a !== 10'(mv))                  errs++;
            if (pix_a !== 1'b1)                   errs++;
            if (req_a !== act)                    errs++;
            if (fs_a !== (mh == 0 && mv == 0))    errs++;
            if (hs_a !== e_hs)                    errs++;
            if (vs_a !== e_vs)                    errs++;
            if (blank_a !== e_blank)              errs++;
            if (r_a !== e_r)                      errs++;
            if (g_a !== e_g)                      errs++;
            if (b_a !== e_b)                      errs++;
            if (uf_a !== e_uf)                    errs++;
            if (drop_c >= 0 && c == drop_c + 1)   drop_rgb = {2'b00, r_a, g_a, b_a};

            if (!hs_a) begin a_hs_low++; if (a_first_hs < 0) a_first_hs = scyc; end
            if (!vs_a) begin a_vs_low++; if (a_first_vs < 0) a_first_vs = scyc; end
            if (req_a) a_req++;
            if (fs_a)  a_fs++;
            if (pix_b) b_pix++;
            if (fs_b)  begin b_fs++; if (b_first_fs < 0) b_first_fs = scyc; end
            if (hs_b)  begin b_hs_hi++; if (b_first_hs < 0) b_first_hs = scyc; end
            if (vs_b)  begin b_vs_hi++; if (b_first_vs < 0) b_first_vs = scyc; end
            if (req_b) b_req++;
            if (blank_b) b_blank++;
            if (r_b !== (blank_b ? 10'h155 : 10'h000)) b_rgb_err++;
            if (g_b !== (blank_b ? 10'h0AA : 10'h000)) b_rgb_err++;

            valid_a = (c != drop_c);
            clr_a   = (c == clr_c);
            g       = 10'(mv * 16 + mh + 1);
            red_a   = 10'h3FF;
            green_a = g;
            blue_a  = ~g;

            if (act && !valid_a)  e_uf = 1'b1;
            else if (clr_a)       e_uf = 1'b0;
            e_r     = (act && valid_a) ? red_a   : 10'h000;
            e_g     = (act && valid_a) ? green_a : 10'h000;
            e_b     = (act && valid_a) ? blue_a  : 10'h000;
            e_hs    = !(mh >= 10 && mh < 13);
            e_vs    = !(mv >= 5 && mv < 7);
            e_blank = act;
            mh++;
            if (mh == 14) begin
                mh = 0;
                mv = (mv == 7) ? 0 : mv + 1;
            end
            scyc++;
            @(posedge clk);
            #1;
        end
        valid_a = 1'b1;
        clr_a   = 1'b0;
        chk({tag, "_model"}, 32'(errs), 32'd0);
    endtask

    // Expected counts for a 224-clk window starting at release from reset
    task automatic check_frame_stats(input string tag);
        chk({tag, "_a_hs_low"},   32'(a_hs_low),   32'd48);
        chk({tag, "_a_vs_low"},   32'(a_vs_low),   32'd56);
        chk({tag, "_a_req"},      32'(a_req),      32'd64);
        chk({tag, "_a_fs"},       32'(a_fs),       32'd2);
        chk({tag, "_a_first_hs"}, 32'(a_first_hs), 32'd11);
        chk({tag, "_a_first_vs"}, 32'(a_first_vs), 32'd71);
        chk({tag, "_b_pix"},      32'(b_pix),      32'd112);
        chk({tag, "_b_fs"},       32'(b_fs),       32'd1);
        chk({tag, "_b_first_fs"}, 32'(b_first_fs), 32'd1);
        chk({tag, "_b_hs_hi"},    32'(b_hs_hi),    32'd48);
        chk({tag, "_b_vs_hi"},    32'(b_vs_hi),    32'd56);
        chk({tag, "_b_req"},      32'(b_req),      32'd32);
        chk({tag, "_b_blank"},    32'(b_blank),    32'd64);
        chk({tag, "_b_rgb"},      32'(b_rgb_err),  32'd0);
        chk({tag, "_b_first_hs"}, 32'(b_first_hs), 32'd22);
        chk({tag, "_b_first_vs"}, 32'(b_first_vs), 32'd142);
    endtask

    initial begin
        rst = 1'b1;
        valid_a = 1'b1; clr_a = 1'b0;
        red_a = 10'h3FF; green_a = 10'h123; blue_a = 10'h2DC;
        valid_b = 1'b1; clr_b = 1'b0;
        red_b = 10'h155; green_b = 10'h0AA; blue_b = 10'h3C3;
        drop_rgb = '1;
        model_reset();
        clear_stats();

        // Reset hold
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hs_a",    32'(hs_a),    32'd1);
        chk("rst_vs_a",    32'(vs_a),    32'd1);
        chk("rst_blank_a", 32'(blank_a), 32'd0);
        chk("rst_red_a",   32'(r_a),     32'd0);
        chk("rst_fs_a",    32'(fs_a),    32'd0);
        chk("rst_pix_a",   32'(pix_a),   32'd0);
        chk("rst_req_a",   32'(req_a),   32'd0);
        chk("rst_h_a",     32'(h_a),     32'd0);
        chk("rst_uf_a",    32'(uf_a),    32'd0);
        chk("rst_sync_a",  32'(sync_a),  32'd0);
        chk("rst_hs_b",    32'(hs_b),    32'd0);
        chk("rst_vs_b",    32'(vs_b),    32'd0);

        // Release: A strobes immediately, B one clock later
        rst = 1'b0;
        #1;
        chk("rel_fs_a",  32'(fs_a),  32'd1);
        chk("rel_req_a", 32'(req_a), 32'd1);
        chk("rel_pix_b", 32'(pix_b), 32'd0);
        chk("rel_fs_b",  32'(fs_b),  32'd0);
        clear_stats();
        model_reset();
        sweep("frame", 224, -1, -1);
        check_frame_stats("p1");

        // Underflow set, hold, clear, concurrent set/clear, idle drop
        sweep("uf_set", 20, 17, -1);
        chk("uf_black",  drop_rgb,    32'd0);
        chk("uf_set",    32'(uf_a),   32'd1);
        sweep("uf_clr", 1, -1, 0);
        chk("uf_clr",    32'(uf_a),   32'd0);
        sweep("uf_both", 1, 0, 0);
        chk("uf_both",   32'(uf_a),   32'd1);
        sweep("uf_clr2", 1, -1, 0);
        chk("uf_clr2",   32'(uf_a),   32'd0);
        sweep("uf_idle", 1, 0, -1);
        chk("uf_idle",   32'(uf_a),   32'd0);

        // Mid-frame asynchronous reset at h=5, v=2
        sweep("pre_rst", 9, -1, -1);
        chk("pre_h_a",     32'(h_a),     32'd5);
        chk("pre_v_a",     32'(v_a),     32'd2);
        chk("pre_blank_a", 32'(blank_a), 32'd1);
        chk("pre_red_a",   32'(r_a),     32'h3FF);
        rst = 1'b1;
        #1;
        chk("arst_h_a",     32'(h_a),     32'd0);
        chk("arst_v_a",     32'(v_a),     32'd0);
        chk("arst_blank_a", 32'(blank_a), 32'd0);
        chk("arst_red_a",   32'(r_a),     32'd0);
        chk("arst_green_a", 32'(g_a),     32'd0);
        chk("arst_hs_a",    32'(hs_a),    32'd1);
        chk("arst_pix_a",   32'(pix_a),   32'd0);
        chk("arst_req_a",   32'(req_a),   32'd0);
        chk("arst_hs_b",    32'(hs_b),    32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold_h_a", 32'(h_a), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel2_fs_a",  32'(fs_a),  32'd1);
        chk("rel2_pix_b", 32'(pix_b), 32'd0);
        clear_stats();
        model_reset();
        sweep("post_rst", 224, -1, -1);
        check_frame_stats("p2");

        chk("uf_b_clean", 32'(uf_b),   32'd0);
        chk("sync_b_tie", 32'(sync_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
